// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one request at a time, drives a byte-lane memory port,
// performs load extraction/merge and store lane alignment, returns data or error.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [31:0]           req_rt,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_data,
   output logic [3:0]            mem_we,
   input  logic [31:0]           mem_q,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err
);

   localparam logic [3:0] OP_LB  = 4'd0,  OP_LBU = 4'd1,  OP_LH  = 4'd2,  OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6;
   localparam logic [3:0] OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10;
   localparam logic [3:0] OP_SWL = 4'd11, OP_SWR = 4'd12;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_nx;
   logic [3:0]  op_r;
   logic [1:0]  b_r;
   logic [31:0] rt_r;
   logic [3:0]  we_r;

   logic [1:0]  req_b;
   logic        illegal, misaligned, bad;
   logic [3:0]  st_we;
   logic [31:0] st_data;

   // Request decode: store lanes are resolved at accept time, so ACCESS only replays them.
   assign req_b = req_addr[1:0];

   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      st_we      = 4'h0;
      st_data    = req_wdata;
      case (req_op)
         OP_LB, OP_LBU, OP_LWL, OP_LWR: ;
         OP_LH, OP_LHU: misaligned = req_b[0];
         OP_LW:         misaligned = |req_b;
         OP_SB: begin
            st_we   = 4'b0001 << req_b;
            st_data = {4{req_wdata[7:0]}};
         end
         OP_SH: begin
            misaligned = req_b[0];
            st_we      = req_b[1] ? 4'b1100 : 4'b0011;
            st_data    = {2{req_wdata[15:0]}};
         end
         OP_SW: begin
            misaligned = |req_b;
            st_we      = 4'hF;
         end
         OP_SWL: begin
            st_we   = ~(4'hE << req_b);
            st_data = req_wdata >> {~req_b, 3'b000};
         end
         OP_SWR: begin
            st_we   = 4'hF << req_b;
            st_data = req_wdata << {req_b, 3'b000};
         end
         default: illegal = 1'b1;
      endcase
   end

   assign bad = illegal | misaligned;

   logic [4:0]  sh_lo, sh_hi;
   logic [31:0] w_sh, ld_data;

   // sh_hi is 8*(3-b); for a 2-bit b, 3-b equals ~b.
   assign sh_lo = {b_r, 3'b000};
   assign sh_hi = {~b_r, 3'b000};
   assign w_sh  = mem_q >> sh_lo;

   always_comb begin
      ld_data = 32'h0;
      case (op_r)
         OP_LB:   ld_data = {{24{w_sh[7]}}, w_sh[7:0]};
         OP_LBU:  ld_data = {24'h0, w_sh[7:0]};
         OP_LH:   ld_data = {{16{w_sh[15]}}, w_sh[15:0]};
         OP_LHU:  ld_data = {16'h0, w_sh[15:0]};
         OP_LW:   ld_data = mem_q;
         OP_LWL:  ld_data = (mem_q << sh_hi) | (rt_r & ~(32'hFFFF_FFFF << sh_hi));
         OP_LWR:  ld_data = (mem_q >> sh_lo) | (rt_r & ~(32'hFFFF_FFFF >> sh_lo));
         default: ld_data = 32'h0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = bad ? RESP : ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_r       <= 4'h0;
         b_r        <= 2'b00;
         rt_r       <= 32'h0;
         we_r       <= 4'h0;
         mem_addr   <= '0;
         mem_data   <= 32'h0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (req_valid) begin
               op_r       <= req_op;
               b_r        <= req_b;
               rt_r       <= req_rt;
               resp_rdata <= 32'h0;
               resp_err   <= bad;
               if (!bad) begin
                  mem_addr <= req_addr;
                  mem_data <= st_data;
                  we_r     <= st_we;
               end
            end
            ACCESS:  resp_rdata <= ld_data;
            default: ;
         endcase
      end
   end

   // Gating with rst_n keeps a reset asserted mid-ACCESS from committing a write.
   assign mem_we     = (state == ACCESS && rst_n) ? we_r : 4'h0;
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

endmodule
